// File: rtl/spi_master_intf.sv
// Byte-level SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
// One byte per start/done handshake. When the cont flag is set, SS stays low
// after the byte, so the host can build multi-byte frames.
module spi_master_intf #(
  parameter int unsigned CLK_DIV = 4  // clk cycles per SCLK half-period, >= 4
) (
  input  logic       clk,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [7:0] tx_data_i,
  input  logic       cont_i,
  output logic       ready_o,
  output logic       busy_o,
  output logic [7:0] rx_data_o,
  output logic       done_o,
  output logic       sclk_o,
  output logic       mosi_o,
  input  logic       miso_i,
  output logic       ss_o
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW,
    S_TAIL
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       tx_q, tx_d;
  logic [7:0]       rx_q, rx_d;
  logic             cont_q, cont_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             done_q, done_d;
  logic             sclk_q, sclk_d;
  logic             mosi_q, mosi_d;
  logic             ss_q, ss_d;
  logic             phase_end;

  assign phase_end = (cnt_q == CNT_W'(CLK_DIV - 1));

  // Next-state logic. The SPI pins are decoded from the next state so that
  // they are registered together with it and change on the same edge.
  always_comb begin
    // NOTE: every signal gets a default before the case, so no path can leave it unassigned and infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    cont_d    = cont_q;
    rx_data_d = rx_data_q;
    done_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          tx_d    = tx_data_i;
          cont_d  = cont_i;
          bit_d   = 3'd0;
          cnt_d   = '0;
          state_d = S_SETUP;
        end
      end
      S_SETUP, S_LOW: begin
        if (phase_end) begin
          cnt_d   = '0;
          rx_d    = {rx_q[6:0], miso_i};  // sample on the SCLK rising edge
          state_d = S_HIGH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (phase_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_TAIL;
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = {tx_q[6:0], 1'b0};  // next bit appears on the SCLK falling edge
            state_d = S_LOW;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_TAIL: begin
        if (phase_end) begin
          cnt_d     = '0;
          done_d    = 1'b1;
          rx_data_d = rx_q;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    sclk_d = (state_d == S_HIGH);
    mosi_d = (state_d == S_IDLE) ? 1'b0 : tx_d[7];
    ss_d   = (state_d == S_IDLE) && !cont_d;
  end

  // State and output registers. The synchronous reset aborts any transfer at once.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_q     <= 3'd0;
      tx_q      <= 8'h00;
      rx_q      <= 8'h00;
      cont_q    <= 1'b0;
      rx_data_q <= 8'h00;
      done_q    <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      ss_q      <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments let every register update from the same pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      cont_q    <= cont_d;
      rx_data_q <= rx_data_d;
      done_q    <= done_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      ss_q      <= ss_d;
    end
  end

  assign ready_o   = (state_q == S_IDLE);
  assign busy_o    = !ready_o;
  assign rx_data_o = rx_data_q;
  assign done_o    = done_q;
  assign sclk_o    = sclk_q;
  assign mosi_o    = mosi_q;
  assign ss_o      = ss_q;

endmodule

// File: tb/tb_spi_master_intf.sv
// Directed bench for spi_master_intf with a mode-0 slave model and a
// scoreboard of expected bytes, popped at every done pulse.
module tb_spi_master_intf;

  localparam int CLK_DIV = 4;
  localparam int LAT     = 17 * CLK_DIV + 1;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       cont = 1'b0;
  logic       ready, busy, done, sclk, mosi, miso, ss;
  logic [7:0] rx_data;

  always #5 clk = ~clk;

  spi_master_intf #(.CLK_DIV(CLK_DIV)) dut (
    .clk       (clk),
    .reset_i   (reset),
    .start_i   (start),
    .tx_data_i (tx_data),
    .cont_i    (cont),
    .ready_o   (ready),
    .busy_o    (busy),
    .rx_data_o (rx_data),
    .done_o    (done),
    .sclk_o    (sclk),
    .mosi_o    (mosi),
    .miso_i    (miso),
    .ss_o      (ss)
  );

  // Slave model: loopback, or a fixed response byte shifted out MSB first.
  logic       loopback = 1'b1;
  logic [7:0] slave_resp = 8'h3C;
  logic [7:0] slv_tx = 8'h00;
  logic [7:0] slv_cap = 8'h00;
  int         pulses = 0;

  assign miso = loopback ? mosi : slv_tx[7];

  always @(negedge sclk or posedge ss or posedge reset)
    if (ss || reset) slv_tx = slave_resp;
    else             slv_tx = {slv_tx[6:0], 1'b0};

  always @(posedge sclk) begin
    pulses  = pulses + 1;
    slv_cap = {slv_cap[6:0], mosi};
  end

  typedef struct packed {
    logic [7:0] tx;
    logic [7:0] rx;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   e_cyc   = 0;
  int   p_base  = 0;
  bit   mon_ss  = 0;
  bit   ss_rose = 0;
  bit   scramble = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (mon_ss && !done && ss) ss_rose = 1;
    if (scramble) begin
      tx_data = 8'($urandom);
      cont    = 1'($urandom);
    end
  endtask

  // Drive one accept edge from the current (ready) cycle.
  task automatic accept(input logic [7:0] tx, input logic c, input logic [7:0] exp_rx,
                        input bit hold);
    exp_t e;
    tx_data = tx;
    cont    = c;
    start   = 1'b1;
    e_cyc   = cyc;
    p_base  = pulses;
    tick();
    if (!hold) start = 1'b0;
    e.tx = tx;
    e.rx = exp_rx;
    sb.push_back(e);
    check("ss_fall", 32'(ss), 32'd0);
    check("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int   n = 0;
    exp_t e;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
    e = sb.pop_front();
    if (done) begin
      check({tag, "_latency"}, 32'(cyc - e_cyc), 32'(LAT));
      check({tag, "_rx"}, 32'(rx_data), 32'(e.rx));
      check({tag, "_slave_cap"}, 32'(slv_cap), 32'(e.tx));
      check({tag, "_pulses"}, 32'(pulses - p_base), 32'd8);
      check({tag, "_ready"}, 32'(ready), 32'd1);
    end
  endtask

  initial begin
    int  n;
    bit  saw_done;

    // Reset state
    #2 reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_ss", 32'(ss), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rx", 32'(rx_data), 32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);

    // 1: 0xA5 out, slave answers 0x3C
    loopback = 1'b0;
    accept(8'hA5, 1'b0, 8'h3C, 0);
    wait_done("t1");
    check("t1_ss_high", 32'(ss), 32'd1);
    tick();
    check("t1_done_pulse", 32'(done), 32'd0);
    check("t1_rx_held", 32'(rx_data), 32'h3C);

    // 2: loopback 0x81 then 0x7E
    loopback = 1'b1;
    repeat (2) tick();
    accept(8'h81, 1'b0, 8'h81, 0);
    wait_done("t2a");
    repeat (3) tick();
    accept(8'h7E, 1'b0, 8'h7E, 0);
    wait_done("t2b");

    // 3: cont frame keeps SS low across both bytes
    repeat (2) tick();
    accept(8'h80, 1'b1, 8'h80, 0);
    mon_ss  = 1;
    ss_rose = 0;
    wait_done("t3a");
    check("t3_ss_low_between", 32'(ss), 32'd0);
    repeat (2) tick();
    accept(8'h5A, 1'b0, 8'h5A, 0);
    wait_done("t3b");
    mon_ss = 0;
    check("t3_ss_never_rose", 32'(ss_rose), 32'd0);
    check("t3_ss_high_end", 32'(ss), 32'd1);

    // 4: start held, inputs scrambled while busy
    repeat (2) tick();
    accept(8'h11, 1'b0, 8'h11, 1);
    scramble = 1;
    wait_done("t4a");
    scramble = 0;
    accept(8'hC3, 1'b0, 8'hC3, 1);
    scramble = 1;
    wait_done("t4b");
    scramble = 0;
    start    = 1'b0;
    cont     = 1'b0;
    tick();
    check("t4_no_third", 32'(ready), 32'd1);

    // 5: reset after the third SCLK rising edge
    repeat (2) tick();
    accept(8'h55, 1'b0, 8'h55, 0);
    n = 0;
    while ((pulses - p_base) < 3 && n < 100) begin
      tick();
      n++;
    end
    check("t5_third_rise", 32'(pulses - p_base), 32'd3);
    void'(sb.pop_back());
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_ss", 32'(ss), 32'd1);
    check("t5_sclk", 32'(sclk), 32'd0);
    check("t5_mosi", 32'(mosi), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    saw_done = 0;
    for (int i = 0; i < LAT + 4; i++) begin
      tick();
      if (done) saw_done = 1;
    end
    check("t5_no_done", 32'(saw_done), 32'd0);
    accept(8'hFF, 1'b0, 8'hFF, 0);
    wait_done("t5b");

    // 6: back-to-back from the done cycle, SS high for exactly one cycle
    loopback = 1'b0;
    repeat (2) tick();
    accept(8'hA5, 1'b0, 8'h3C, 0);
    wait_done("t6a");
    check("t6_ss_high_done", 32'(ss), 32'd1);
    accept(8'hA5, 1'b0, 8'h3C, 0);
    wait_done("t6b");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
